// File: rtl/cla_pkg.sv
// Shared types and constants for the time-shared carry-lookahead adder.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit generate/propagate carry-lookahead slice.
// c3 is the carry into bit 3, exposed so the caller can derive signed overflow.
module cla_nibble
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | ((&w_p) & cin);

    assign s    = w_p ^ w_c[NIB_W-1:0];
    assign cout = w_c[NIB_W];
    assign c3   = w_c[NIB_W-1];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit lookahead slice, one nibble per cycle,
// LSB first, with the inter-nibble carry held in a register.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;

    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic [NIB_W-1:0]   w_nib_s;
    logic               w_nib_cout;
    logic               w_nib_c3;

    assign w_nib_a = r_a[NIB_W*int'(r_idx) +: NIB_W];
    assign w_nib_b = r_b[NIB_W*int'(r_idx) +: NIB_W];

    cla_nibble u_nibble (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .s    (w_nib_s),
        .cout (w_nib_cout),
        .c3   (w_nib_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == LAST_IDX) w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only the final nibble's carries determine the unsigned carry and signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum[NIB_W*int'(r_idx) +: NIB_W] <= w_nib_s;
                    r_carry <= w_nib_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout <= w_nib_cout;
                        r_ovf  <= w_nib_c3 ^ w_nib_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboarded bench for cla_seq_adder: directed cases on a 16-bit instance,
// then randomized traffic with output stalls on 16-, 8- and 32-bit instances.
module tb_cla_seq_adder;

    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv16, ir16, ov16, or16, cin16, co16, of16, bz16;
    logic [15:0] a16, b16, s16;
    logic        iv8, ir8, ov8, or8, cin8, co8, of8, bz8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, ov32, or32, cin32, co32, of32, bz32;
    logic [31:0] a32, b32, s32;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q32[$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_done = 1'b0;
    bit finished  = 1'b0;

    cla_seq_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
        .ovf(of16), .busy(bz16)
    );

    cla_seq_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
        .ovf(of8), .busy(bz8)
    );

    cla_seq_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32),
        .ovf(of32), .busy(bz32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer addition, with overflow judged on the signed values.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic c);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] full;
        longint      lim, sa, sb, ss;
        mask   = (64'd1 << w) - 64'd1;
        full   = (a & mask) + (b & mask) + 64'(c);
        e.sum  = full & mask;
        e.cout = full[w];
        lim    = longint'(64'd1 << (w - 1));
        sa     = longint'(a & mask);
        sb     = longint'(b & mask);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        ss     = sa + sb + longint'({63'd0, c});
        e.ovf  = (ss >= lim) || (ss < -lim);
        return e;
    endfunction

    task automatic mon16();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ov16 && or16) begin
                check("busy16_done", 64'(bz16), 64'd1);
                check("q16_has_entry", 64'(q16.size() != 0), 64'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("sum16", 64'(s16), e.sum);
                    check("cout16", 64'(co16), 64'(e.cout));
                    check("ovf16", 64'(of16), 64'(e.ovf));
                end
            end
        end
    endtask

    task automatic mon8();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ov8 && or8) begin
                check("busy8_done", 64'(bz8), 64'd1);
                check("q8_has_entry", 64'(q8.size() != 0), 64'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("sum8", 64'(s8), e.sum);
                    check("cout8", 64'(co8), 64'(e.cout));
                    check("ovf8", 64'(of8), 64'(e.ovf));
                end
            end
        end
    endtask

    task automatic mon32();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ov32 && or32) begin
                check("busy32_done", 64'(bz32), 64'd1);
                check("q32_has_entry", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    check("sum32", 64'(s32), e.sum);
                    check("cout32", 64'(co32), 64'(e.cout));
                    check("ovf32", 64'(of32), 64'(e.ovf));
                end
            end
        end
    endtask

    // Issue one op from IDLE on the 16-bit DUT and track it to DONE; result left unconsumed.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(posedge clk); #1;
        a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
        @(negedge clk);
        check("idle_ready16", 64'(ir16), 64'd1);
        q16.push_back(model(16, 64'(a), 64'(b), c));
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("latency_ov16", 64'(ov16), 64'(k == 4));
            check("run_in_ready16", 64'(ir16), 64'd0);
            check("run_busy16", 64'(bz16), 64'd1);
        end
    endtask

    task automatic drain16();
        @(posedge clk); #1 or16 = 1'b1;
        @(posedge clk); #1 or16 = 1'b0;
        @(negedge clk);
        check("ready_after16", 64'(ir16), 64'd1);
        check("ov_after16", 64'(ov16), 64'd0);
    endtask

    task automatic drv16();
        bit acc;
        for (int i = 0; i < N_RAND; i++) begin
            @(posedge clk); #1;
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                if (ir16) begin
                    q16.push_back(model(16, 64'(a16), 64'(b16), cin16));
                    acc = 1'b1;
                end
            end
            check("accept16", 64'(acc), 64'd1);
            @(posedge clk); #1 iv16 = 1'b0;
        end
    endtask

    task automatic drv8();
        bit acc;
        for (int i = 0; i < N_RAND; i++) begin
            @(posedge clk); #1;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                if (ir8) begin
                    q8.push_back(model(8, 64'(a8), 64'(b8), cin8));
                    acc = 1'b1;
                end
            end
            check("accept8", 64'(acc), 64'd1);
            @(posedge clk); #1 iv8 = 1'b0;
        end
    endtask

    task automatic drv32();
        bit acc;
        for (int i = 0; i < N_RAND; i++) begin
            @(posedge clk); #1;
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); iv32 = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                if (ir32) begin
                    q32.push_back(model(32, 64'(a32), 64'(b32), cin32));
                    acc = 1'b1;
                end
            end
            check("accept32", 64'(acc), 64'd1);
            @(posedge clk); #1 iv32 = 1'b0;
        end
    endtask

    task automatic toggle_ready();
        while (!rand_done) begin
            @(posedge clk); #1;
            or16 = ($urandom_range(0, 2) != 0);
            or8  = ($urandom_range(0, 2) != 0);
            or32 = ($urandom_range(0, 2) != 0);
        end
        or16 = 1'b0; or8 = 1'b0; or32 = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        iv16 = 0; or16 = 0; cin16 = 0; a16 = '0; b16 = '0;
        iv8  = 0; or8  = 0; cin8  = 0; a8  = '0; b8  = '0;
        iv32 = 0; or32 = 0; cin32 = 0; a32 = '0; b32 = '0;

        fork
            begin
                #1_000_000;
                check("watchdog_finished", 64'(finished), 64'd1);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $fatal(1, "watchdog expired");
            end
            mon16();
            mon8();
            mon32();
        join_none

        #12;
        check("rst_in_ready16", 64'(ir16), 64'd1);
        check("rst_out_valid16", 64'(ov16), 64'd0);
        check("rst_busy16", 64'(bz16), 64'd0);
        check("rst_sum16", 64'(s16), 64'd0);
        check("rst_cout16", 64'(co16), 64'd0);
        check("rst_ovf16", 64'(of16), 64'd0);
        check("rst_in_ready8", 64'(ir8), 64'd1);
        check("rst_out_valid32", 64'(ov32), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        op16(16'h1234, 16'h4321, 1'b0); drain16();
        op16(16'hFFFF, 16'h0001, 1'b0); drain16();
        op16(16'h0000, 16'h0000, 1'b1); drain16();
        op16(16'h7FFF, 16'h0001, 1'b0); drain16();
        op16(16'h8000, 16'h8000, 1'b0); drain16();

        // Backpressure: DONE must freeze while new operands are offered.
        e = model(16, 64'h0000_0000_0000_A5A5, 64'h0000_0000_0000_5A5A, 1'b1);
        op16(16'hA5A5, 16'h5A5A, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            iv16 = ~iv16; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            @(negedge clk);
            check("bp_sum16", 64'(s16), e.sum);
            check("bp_cout16", 64'(co16), 64'(e.cout));
            check("bp_ovf16", 64'(of16), 64'(e.ovf));
            check("bp_in_ready16", 64'(ir16), 64'd0);
            check("bp_out_valid16", 64'(ov16), 64'd1);
        end
        iv16 = 1'b0;
        drain16();

        // Reset asserted between clock edges during the second RUN cycle.
        @(posedge clk); #1;
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1 iv16 = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid16", 64'(ov16), 64'd0);
        check("mid_rst_sum16", 64'(s16), 64'd0);
        check("mid_rst_in_ready16", 64'(ir16), 64'd1);
        check("mid_rst_busy16", 64'(bz16), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        op16(16'h00FF, 16'h0F01, 1'b0); drain16();

        fork
            toggle_ready();
        join_none
        fork
            drv16();
            drv8();
            drv32();
        join
        for (int k = 0; k < 400 && (q16.size() + q8.size() + q32.size()) != 0; k++)
            @(posedge clk);
        rand_done = 1'b1;
        repeat (3) @(posedge clk);
        check("q16_drained", 64'(q16.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        check("q32_drained", 64'(q32.size()), 64'd0);

        finished = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
